// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard/stall sequencer for the 5-stage core: data-hazard and branch detection,
// data-memory wait FSM with watchdog, and saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int REG_W   = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_src1,
  input  logic             id_use_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             fwd_en,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             clr_cnt,
  output logic             pc_freeze,
  output logic             if_freeze,
  output logic             if_flush,
  output logic             id_flush,
  output logic             back_freeze,
  output logic             mem_state,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  mem_state_e              state_r;
  mem_state_e              state_nxt_s;
  logic [WAIT_W-1:0]       wait_cnt_r;
  logic [WAIT_W-1:0]       wait_cnt_nxt_s;
  logic                    timeout_set_s;
  logic                    timeout_r;
  logic [CNT_W-1:0]        stall_cnt_r;
  logic [CNT_W-1:0]        flush_cnt_r;
  logic                    exe_haz_s;
  logic                    mem_haz_s;
  logic                    data_haz_s;
  logic                    mem_wait_s;

  function automatic logic src_hit(input logic use_src, input logic [REG_W-1:0] src,
                                   input logic [REG_W-1:0] dest);
    return use_src & (src == dest);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    if (val == {CNT_W{1'b1}}) begin
      return val;
    end else begin
      return val + CNT_W'(1);
    end
  endfunction

  // Hazard detection against the EXE and MEM destinations
  always_comb begin
    exe_haz_s  = 1'b0;
    mem_haz_s  = 1'b0;
    data_haz_s = 1'b0;
    mem_wait_s = mem_req & ~mem_ready;
    exe_haz_s  = exe_wb_en & (src_hit(id_use_src1, id_src1, exe_dest) |
                              src_hit(id_two_src,  id_src2, exe_dest));
    mem_haz_s  = mem_wb_en & (src_hit(id_use_src1, id_src1, mem_dest) |
                              src_hit(id_two_src,  id_src2, mem_dest));
    // With forwarding only a load result is too late for the consumer
    if (fwd_en) begin
      data_haz_s = exe_haz_s & exe_mem_read;
    end else begin
      data_haz_s = exe_haz_s | mem_haz_s;
    end
  end

  // Prioritised pipeline controls: memory wait > taken branch > data hazard
  always_comb begin
    pc_freeze   = 1'b0;
    if_freeze   = 1'b0;
    if_flush    = 1'b0;
    id_flush    = 1'b0;
    back_freeze = 1'b0;
    if (mem_wait_s) begin
      pc_freeze   = 1'b1;
      if_freeze   = 1'b1;
      back_freeze = 1'b1;
    end else if (branch_taken) begin
      if_flush = 1'b1;
      id_flush = 1'b1;
    end else if (data_haz_s) begin
      pc_freeze = 1'b1;
      if_freeze = 1'b1;
      id_flush  = 1'b1;
    end else begin
      pc_freeze = 1'b0;
    end
  end

  // Memory FSM next state and watchdog counter next value
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = {WAIT_W{1'b0}};
    timeout_set_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mem_wait_s) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (mem_wait_s) begin
          state_nxt_s = ST_WAIT;
          // Counter stops at TIMEOUT; the flag is raised on the cycle it gets there
          if (wait_cnt_r >= WAIT_W'(TIMEOUT - 1)) begin
            wait_cnt_nxt_s = WAIT_W'(TIMEOUT);
            timeout_set_s  = 1'b1;
          end else begin
            wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and watchdog registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= {WAIT_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
    end
  end

  // Sticky timeout flag, cleared only by reset or clr_cnt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_r <= 1'b0;
    end else if (clr_cnt) begin
      timeout_r <= 1'b0;
    end else if (timeout_set_s) begin
      timeout_r <= 1'b1;
    end
  end

  // Saturating performance counters; clear wins over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else if (clr_cnt) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (pc_freeze) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end
      if (if_flush) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end
    end
  end

  assign mem_state   = state_r;
  assign mem_timeout = timeout_r;
  assign stall_count = stall_cnt_r;
  assign flush_count = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed vector bench for pipeline_hazard_ctrl: table of combinational cases plus
// hand-written memory-wait, watchdog, saturation and reset sequences.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
  logic       id_use_src1, id_two_src, exe_wb_en, exe_mem_read, mem_wb_en;
  logic       fwd_en, branch_taken, mem_req, mem_ready, clr_cnt;
  logic       pc_freeze, if_freeze, if_flush, id_flush, back_freeze, mem_state, mem_timeout;
  logic [15:0] stall_count, flush_count;
  logic       s_pc_freeze, s_if_freeze, s_if_flush, s_id_flush, s_back_freeze, s_mem_state, s_mem_timeout;
  logic [1:0] s_stall_count, s_flush_count;
  logic [4:0] ctrl;

  int n_vec = 0;
  int n_err = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  typedef struct {
    string      name;
    logic [3:0] src1;  logic use1;
    logic [3:0] src2;  logic two;
    logic [3:0] edst;  logic ewb; logic erd;
    logic [3:0] mdst;  logic mwb;
    logic       fwd, br, req, rdy;
    logic [4:0] exp;   // {pc_freeze, if_freeze, if_flush, id_flush, back_freeze}
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  assign ctrl = {pc_freeze, if_freeze, if_flush, id_flush, back_freeze};

  pipeline_hazard_ctrl #(.REG_W(4), .CNT_W(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_use_src1(id_use_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .fwd_en(fwd_en), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .clr_cnt(clr_cnt),
    .pc_freeze(pc_freeze), .if_freeze(if_freeze), .if_flush(if_flush), .id_flush(id_flush),
    .back_freeze(back_freeze), .mem_state(mem_state), .mem_timeout(mem_timeout),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  pipeline_hazard_ctrl #(.REG_W(4), .CNT_W(2), .TIMEOUT(255)) dut_sat (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_use_src1(id_use_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .fwd_en(fwd_en), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .clr_cnt(clr_cnt),
    .pc_freeze(s_pc_freeze), .if_freeze(s_if_freeze), .if_flush(s_if_flush), .id_flush(s_id_flush),
    .back_freeze(s_back_freeze), .mem_state(s_mem_state), .mem_timeout(s_mem_timeout),
    .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  function automatic vec_t mk(string nm, logic [3:0] s1, logic u1, logic [3:0] s2, logic tw,
                              logic [3:0] ed, logic ew, logic er, logic [3:0] md, logic mw,
                              logic fw, logic b, logic rq, logic rd, logic [4:0] e);
    vec_t v;
    v.name = nm; v.src1 = s1; v.use1 = u1; v.src2 = s2; v.two = tw;
    v.edst = ed; v.ewb = ew; v.erd = er; v.mdst = md; v.mwb = mw;
    v.fwd = fw; v.br = b; v.req = rq; v.rdy = rd; v.exp = e;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    id_src1 = v.src1; id_use_src1 = v.use1; id_src2 = v.src2; id_two_src = v.two;
    exe_dest = v.edst; exe_wb_en = v.ewb; exe_mem_read = v.erd;
    mem_dest = v.mdst; mem_wb_en = v.mwb; fwd_en = v.fwd;
    branch_taken = v.br; mem_req = v.req; mem_ready = v.rdy;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  // Advance to the next falling edge and check the counters against the bench model
  task automatic tick(input logic pcf, input logic ifl, input logic clr);
    @(negedge clk);
    if (clr) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      exp_stall = exp_stall + int'(pcf);
      exp_flush = exp_flush + int'(ifl);
    end
    chk("stall_count", 32'(stall_count), 32'(exp_stall));
    chk("flush_count", 32'(flush_count), 32'(exp_flush));
  endtask

  vec_t idle_v, lu_v, v;

  initial begin
    idle_v = mk("idle", 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000);
    lu_v   = mk("load_use", 4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11010);
    vecs.push_back(lu_v);
    vecs.push_back(mk("fwd_no_load",   4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000));
    vecs.push_back(mk("nofwd_mem_src2",4'd0, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11010));
    vecs.push_back(mk("nofwd_two_off", 4'd0, 1'b0, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000));
    vecs.push_back(mk("branch_over_lu",4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00110));
    vecs.push_back(mk("nofwd_exe_alu", 4'd7, 1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11010));
    vecs.push_back(mk("nofwd_exe_nowb",4'd7, 1'b1, 4'd0, 1'b0, 4'd7, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000));
    vecs.push_back(mk("src1_unused",   4'd7, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000));
    vecs.push_back(mk("fwd_mem_haz",   4'd6, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00000));
    vecs.push_back(mk("lu_src2",       4'd0, 1'b0, 4'd9, 1'b1, 4'd9, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11010));
    vecs.push_back(mk("ready_no_req",  4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00000));
    vecs.push_back(mk("req_ready_same",4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00000));
    vecs.push_back(mk("mismatch_dest", 4'd2, 1'b1, 4'd4, 1'b1, 4'd3, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000));

    rst = 1'b1; clr_cnt = 1'b0;
    drive(idle_v);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_ctrl", 32'(ctrl), 32'd0);
    chk("reset_mem_state", 32'(mem_state), 32'd0);
    chk("reset_timeout", 32'(mem_timeout), 32'd0);
    chk("reset_stall", 32'(stall_count), 32'd0);
    chk("reset_flush", 32'(flush_count), 32'd0);
    @(negedge clk);

    // Table: combinational controls, FSM stays idle, counters track the model
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v);
      #1;
      chk({"ctrl_", v.name}, 32'(ctrl), 32'(v.exp));
      chk({"state_", v.name}, 32'(mem_state), 32'd0);
      tick(v.exp[4], v.exp[2], 1'b0);
    end

    // Memory wait of 3 cycles with a taken branch held throughout
    v = idle_v; v.req = 1'b1; v.br = 1'b1; drive(v);
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk("wait_ctrl", 32'(ctrl), 32'b11001);
      chk("wait_state", 32'(mem_state), (k == 1) ? 32'd0 : 32'd1);
      tick(1'b1, 1'b0, 1'b0);
    end
    mem_ready = 1'b1;
    #1;
    chk("release_ctrl", 32'(ctrl), 32'b00110);
    chk("release_state", 32'(mem_state), 32'd1);
    tick(1'b0, 1'b1, 1'b0);
    drive(idle_v);
    #1;
    chk("after_release_state", 32'(mem_state), 32'd0);
    chk("after_release_ctrl", 32'(ctrl), 32'd0);
    chk("no_timeout_short", 32'(mem_timeout), 32'd0);
    tick(1'b0, 1'b0, 1'b0);

    // Watchdog with TIMEOUT=4: six stalled cycles, flag follows the 4th WAIT cycle
    v = idle_v; v.req = 1'b1; drive(v);
    for (int k = 1; k <= 6; k++) begin
      #1;
      chk("wd_timeout", 32'(mem_timeout), (k == 6) ? 32'd1 : 32'd0);
      chk("wd_back_freeze", 32'(back_freeze), 32'd1);
      tick(1'b1, 1'b0, 1'b0);
    end
    drive(idle_v);
    #1;
    chk("wd_sticky", 32'(mem_timeout), 32'd1);
    tick(1'b0, 1'b0, 1'b0);
    chk("wd_sticky_idle", 32'(mem_timeout), 32'd1);
    clr_cnt = 1'b1;
    tick(1'b0, 1'b0, 1'b1);
    clr_cnt = 1'b0;
    chk("clr_timeout", 32'(mem_timeout), 32'd0);
    chk("clr_sat_stall", 32'(s_stall_count), 32'd0);

    // Saturation on the 2-bit counter instance
    drive(lu_v);
    for (int k = 1; k <= 5; k++) begin
      tick(1'b1, 1'b0, 1'b0);
      chk("sat_stall", 32'(s_stall_count), (k > 3) ? 32'd3 : 32'(k));
    end
    // Clear wins over a simultaneous increment
    clr_cnt = 1'b1;
    tick(1'b1, 1'b0, 1'b1);
    clr_cnt = 1'b0;
    chk("clr_over_inc", 32'(s_stall_count), 32'd0);

    // Asynchronous reset while waiting on memory
    v = idle_v; v.req = 1'b1; drive(v);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("pre_rst_state", 32'(mem_state), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_state", 32'(mem_state), 32'd0);
    chk("rst_stall", 32'(stall_count), 32'd0);
    chk("rst_flush", 32'(flush_count), 32'd0);
    chk("rst_sat_stall", 32'(s_stall_count), 32'd0);
    @(negedge clk);
    drive(idle_v);
    rst = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
    tick(1'b0, 1'b0, 1'b0);
    chk("post_rst_state", 32'(mem_state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
